// File: rtl/div_unit_if.sv
// Handshake and data bundle between the execute-stage pipeline and the divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               annul;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  // Pipeline side drives the request, divider side drives status and result.
  modport master (
    output start, signed_div, opa, opb, annul,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, opa, opb, annul,
    output busy, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Returns {remainder, quotient}
// for the HI/LO write; fixed latency of WIDTH+1 cycles, two cycles for divide-by-zero.
module div_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] ZERO_QUOT = '1
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave io_bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntMax = CW'(WIDTH);
  localparam logic [CW-1:0] CntOne = CW'(1);

  typedef enum logic [1:0] {StIdle, StOn, StDzero, StDone} state_e;

  state_e               r_state;
  logic [WIDTH:0]       r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_sign_q;
  logic                 r_sign_r;
  logic                 r_busy;
  logic                 r_ready;
  logic [2*WIDTH-1:0]   r_result;
  logic [CW-1:0]        r_cnt;

  logic                 w_opa_neg;
  logic                 w_opb_neg;
  logic [WIDTH-1:0]     w_opa_abs;
  logic [WIDTH-1:0]     w_opb_abs;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH-1:0]     w_quo_sh;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_quo_fix;

  // Operand magnitudes, one shift-subtract step and final sign correction.
  always_comb begin
    w_opa_neg = io_bus.signed_div & io_bus.opa[WIDTH-1];
    w_opb_neg = io_bus.signed_div & io_bus.opb[WIDTH-1];
    w_opa_abs = w_opa_neg ? -io_bus.opa : io_bus.opa;
    w_opb_abs = w_opb_neg ? -io_bus.opb : io_bus.opb;
    w_rem_sh  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_quo_sh  = {r_quo[WIDTH-2:0], 1'b0};
    w_trial   = w_rem_sh - {1'b0, r_divisor};
    w_rem_fix = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    w_quo_fix = r_sign_q ? -r_quo : r_quo;
  end

  // Control FSM and datapath registers; annul outranks everything but rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
      r_cnt     <= '0;
    end else if (io_bus.annul) begin
      // result is deliberately left untouched
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_divisor <= w_opb_abs;
            r_sign_q  <= w_opa_neg ^ w_opb_neg;
            r_sign_r  <= w_opa_neg;
            if (io_bus.opb == '0) begin
              // raw dividend is what gets reported as the remainder
              r_quo   <= io_bus.opa;
              r_state <= StDzero;
            end else begin
              r_quo   <= w_opa_abs;
              r_state <= StOn;
            end
          end
        end
        StOn: begin
          if (r_cnt == CntMax) begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_rem <= w_trial[WIDTH] ? w_rem_sh : w_trial;
            r_quo <= {w_quo_sh[WIDTH-1:1], ~w_trial[WIDTH]};
            r_cnt <= r_cnt + CntOne;
          end
        end
        StDzero: begin
          // two cycles here so ready lands two edges after the accept edge
          if (r_cnt == CntOne) begin
            r_result <= {r_quo, ZERO_QUOT};
            r_ready  <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.busy   = r_busy;
  assign io_bus.ready  = r_ready;
  assign io_bus.result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results, latency and
// control-path checks (annul, start while busy, asynchronous reset).
module tb_div_unit;

  logic clk;
  logic rst;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .ZERO_QUOT(32'hFFFF_FFFF)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned n_ready = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Scoreboard consumer: every ready pops one expected result.
  always @(posedge clk) begin
    #1;
    if (bus.ready === 1'b1) begin
      n_ready++;
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        last_res = sb_q.pop_front();
        check("result", bus.result, last_res);
      end
    end
  end

  // Drive one start; returns at accept edge + 1. Operands are scrambled afterwards.
  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit push);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.opa        = a;
    bus.opb        = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.opa   = $urandom;
    bus.opb   = $urandom;
    if (push) sb_q.push_back(exp);
  endtask

  task automatic wait_ready(input string tag, input int exp_lat);
    int cycles = 0;
    while (cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.ready === 1'b1) break;
    end
    check(tag, 64'(cycles), 64'(exp_lat));
    check({tag, "_busy_in_ready"}, 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic op(input bit s, input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] exp, input int lat);
    launch(s, a, b, exp, 1'b1);
    wait_ready("latency", lat);
  endtask

  initial begin
    int unsigned rdy0;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opa        = '0;
    bus.opb        = '0;
    bus.annul      = 1'b0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived expectations
    op(1'b0, 32'd7, 32'd2, {32'h1, 32'h3}, 33);
    op(1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    op(1'b1, 32'd7, -32'sd2, {32'h1, 32'hFFFF_FFFD}, 33);
    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33);
    op(1'b0, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF}, 2);
    op(1'b1, -32'sd5, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 2);
    op(1'b0, 32'd3, 32'd9, {32'h3, 32'h0}, 33);

    // Random operands against the behavioural model
    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i == 0) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
      op(rs, ra, rb, model(rs, ra, rb), (rb == 0) ? 2 : 33);
    end

    // Annul mid-operation: no ready, idle, result unchanged
    rdy0 = n_ready;
    launch(1'b0, 32'd7, 32'd2, '0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    check("annul_busy", 64'(bus.busy), 64'd0);
    check("annul_ready", 64'(bus.ready), 64'd0);
    check("annul_result", bus.result, last_res);
    op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    check("annul_ready_count", 64'(n_ready - rdy0), 64'd1);

    // Annul and start in the same idle cycle: start dropped
    @(negedge clk);
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.opa   = 32'd9;
    bus.opb   = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    check("annul_start_busy", 64'(bus.busy), 64'd0);

    // start held high throughout: one ready per operation, start ignored in DONE
    rdy0 = n_ready;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa        = 32'd1000;
    bus.opb        = 32'd3;
    @(posedge clk);
    #1;
    sb_q.push_back({32'd1, 32'd333});
    for (int i = 1; i <= 35; i++) begin
      @(posedge clk);
      #1;
      if (i == 33) check("held_ready", 64'(bus.ready), 64'd1);
      if (i == 34) check("held_busy_drop", 64'(bus.busy), 64'd0);
      if (i == 35) check("held_reaccept", 64'(bus.busy), 64'd1);
    end
    check("held_ready_count", 64'(n_ready - rdy0), 64'd1);
    sb_q.push_back({32'd1, 32'd333});

    // Asynchronous reset mid-operation, sampled before any clock edge
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_ready", 64'(bus.ready), 64'd0);
    check("arst_result", bus.result, 64'd0);
    sb_q.delete();
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_ready_count", 64'(n_ready - rdy0), 64'd1);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
